// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   DATA_W                     - data / address word width (32)
//   LATENCY_MIN / LATENCY_MAX  - legal range of the response latency
//   state_t, ST_*              - FSM state encoding (IDLE, WAIT, RESP)
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int DATA_W      = 32;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH x DATA_W word storage with a synchronous write port and a registered
// read-capture port. The capture register is the response data register: it
// is loaded once per accepted request and holds until the next one, so later
// writes cannot disturb a pending load result.
//
// Ports:
//   clk       - clock, rising edge
//   RN        - asynchronous active-low reset; clears every word and rdata
//   wr_en     - write wdata to word idx on this edge
//   cap_en    - load the capture register on this edge
//   cap_load  - when capturing: 1 = capture word idx, 0 = capture zero
//   idx       - word index
//   wdata     - write data
//   rdata     - captured response data
// -----------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic              clk,
  input  logic              RN,
  input  logic              wr_en,
  input  logic              cap_en,
  input  logic              cap_load,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              idx_ok;

  // Only matters for non-power-of-two DEPTH, where idx can name a missing word.
  assign idx_ok = ({1'b0, idx} < (IDX_W + 1)'(DEPTH));

  // NOTE: the storage must read back as zero after reset, so it is built from
  // resettable flops rather than a RAM macro; the loop is unrolled at
  // elaboration into one clear per word.
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (wr_en && idx_ok) begin
        mem[idx] <= wdata;
      end
      if (cap_en) begin
        rdata <= (cap_load && idx_ok) ? mem[idx] : '0;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Single-outstanding load/store responder with a fixed response latency.
// A request is accepted in IDLE; the FSM then waits LATENCY cycles in total
// (WAIT, then RESP) and holds the response in RESP until rsp_ready.
//
// Build option:
//   DMEM_RESPONDER_ERR_EN defined   - addresses >= DEPTH flag rsp_err, stores
//                                     to them are dropped, loads return 0
//   DMEM_RESPONDER_ERR_EN undefined - address wraps modulo DEPTH (low index
//                                     bits), rsp_err is constant 0
//
// Ports:
//   clk        - clock, rising edge
//   RN         - asynchronous active-low reset
//   req_valid  - request present           req_ready - accepting (IDLE only)
//   req_we     - 1 store / 0 load          req_addr  - word address
//   req_wdata  - store data
//   rsp_valid  - response present (RESP)   rsp_ready - response taken
//   rsp_rdata  - load data, 0 for stores and errors
//   rsp_err    - address out of range
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              RN,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Out-of-range LATENCY values are clamped into the supported window.
  localparam int LAT   = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                         (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [1:0] CNT_LOAD = 2'(LAT - 1);

  state_t           state;
  logic [1:0]       cnt;
  logic             accept;
  logic             in_range;
  logic [IDX_W-1:0] idx;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[IDX_W-1:0];

`ifdef DMEM_RESPONDER_ERR_EN
  assign in_range = (req_addr < 32'(DEPTH));
`else
  assign in_range = 1'b1;
  // Upper address bits are intentionally discarded by the wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[DATA_W-1:IDX_W];
`endif

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk      (clk),
    .RN       (RN),
    .wr_en    (accept && req_we && in_range),
    .cap_en   (accept),
    .cap_load (!req_we && in_range),
    .idx      (idx),
    .wdata    (req_wdata),
    .rdata    (rsp_rdata)
  );

  // NOTE: all state below uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order in the block.
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (LAT == 1) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          // Leave on the edge where the counter steps from 1 to 0.
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMEM_RESPONDER_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= !in_range;
    end
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench for dmem_responder. Two instances: dut (LATENCY=2) and
// dut_b (LATENCY=1, rsp_ready tied high). Expected results come from a
// word-array model of the memory and the latency rules; inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH = 32;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        RN;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;

  assign b_rsp_ready = 1'b1;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .RN(RN),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_b (
    .clk(clk), .RN(RN),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model   [DEPTH];
  logic [31:0] model_b [DEPTH];

  // ---------------- reference model ----------------
  task automatic clear_models();
    for (int i = 0; i < DEPTH; i++) begin
      model[i]   = '0;
      model_b[i] = '0;
    end
  endtask

  function automatic logic ref_err(input logic [31:0] a);
`ifdef DMEM_RESPONDER_ERR_EN
    return (a >= DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_read(input bit use_b, input logic [31:0] a);
    if (ref_err(a)) return '0;
    return use_b ? model_b[a % DEPTH] : model[a % DEPTH];
  endfunction

  function automatic logic [31:0] ref_rsp(input bit use_b, input logic we, input logic [31:0] a);
    return we ? 32'd0 : ref_read(use_b, a);
  endfunction

  task automatic ref_store(input bit use_b, input logic [31:0] a, input logic [31:0] d);
    if (ref_err(a)) return;
    if (use_b) model_b[a % DEPTH] = d;
    else       model[a % DEPTH]   = d;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_junk();
    req_valid = 1'b1;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 2 * DEPTH - 1));
  endfunction

  // One transaction on dut, starting and ending just after a falling edge.
  // lat: falling edges after the accept edge until rsp_valid (-1 on timeout).
  // stable: rdata/err/valid held and req_ready low for the whole response.
  // post_ok: back in IDLE with rsp_valid low after the handshake.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input int hold, input bit junk,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output bit stable, output bit post_ok);
    lat = -1; stable = 1'b1; post_ok = 1'b0; rdata = '0; err = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = data; rsp_ready = 1'b0;
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (junk) drive_junk(); else req_valid = 1'b0;
      if (req_ready !== 1'b0) stable = 1'b0;
      if (rsp_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat > 0) begin
      rdata = rsp_rdata;
      err   = rsp_err;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (junk) drive_junk();
        if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== err || req_ready !== 1'b0)
          stable = 1'b0;
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    post_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_hold: valid=%b rdata=%h err=%b ready=%b, want 0 0 0 1",
               rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
    repeat (2) @(negedge clk);
    RN = 1'b1;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || b_rsp_valid !== 1'b0 || b_req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: valid=%b ready=%b b_valid=%b b_ready=%b, want 0 1 0 1",
               rsp_valid, req_ready, b_rsp_valid, b_req_ready);
    end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er; bit st, po;
    do_txn(1'b1, 32'd5, 32'hDEADBEEF, 0, 1'b0, lat, rd, er, st, po);
    ref_store(1'b0, 32'd5, 32'hDEADBEEF);
    vectors++;
    if (lat != LAT || rd !== 32'd0 || er !== 1'b0 || !st || !po) begin
      miscompares++;
      $display("FAIL store5: lat=%0d rdata=%h err=%b stable=%b idle_after=%b, want lat=%0d rdata=0 err=0 1 1",
               lat, rd, er, st, po, LAT);
    end
    do_txn(1'b0, 32'd5, 32'h0, 0, 1'b0, lat, rd, er, st, po);
    vectors++;
    if (lat != LAT || rd !== 32'hDEADBEEF || er !== 1'b0 || !st || !po) begin
      miscompares++;
      $display("FAIL load5: lat=%0d rdata=%h err=%b stable=%b idle_after=%b, want lat=%0d rdata=deadbeef err=0 1 1",
               lat, rd, er, st, po, LAT);
    end
  endtask

  task automatic test_hold();
    int lat; logic [31:0] rd, d; logic er; bit st, po;
    d = $urandom;
    do_txn(1'b1, 32'd3, d, 0, 1'b0, lat, rd, er, st, po);
    ref_store(1'b0, 32'd3, d);
    do_txn(1'b0, 32'd3, 32'h0, 4, 1'b1, lat, rd, er, st, po);
    vectors++;
    if (lat != LAT || rd !== d || er !== 1'b0 || !st || !po) begin
      miscompares++;
      $display("FAIL hold_load3: lat=%0d rdata=%h err=%b stable=%b idle_after=%b, want lat=%0d rdata=%h err=0 1 1",
               lat, rd, er, st, po, LAT, d);
    end
  endtask

  task automatic test_addr_range();
    int lat; logic [31:0] rd; logic er; bit st, po;
`ifdef DMEM_RESPONDER_ERR_EN
    do_txn(1'b0, 32'd40, 32'h0, 0, 1'b0, lat, rd, er, st, po);
    vectors++;
    if (lat != LAT || rd !== 32'd0 || er !== 1'b1 || !st || !po) begin
      miscompares++;
      $display("FAIL err_load40: lat=%0d rdata=%h err=%b stable=%b idle_after=%b, want lat=%0d rdata=0 err=1 1 1",
               lat, rd, er, st, po, LAT);
    end
    do_txn(1'b1, 32'd40, 32'h11, 0, 1'b0, lat, rd, er, st, po);
    do_txn(1'b0, 32'd8, 32'h0, 0, 1'b0, lat, rd, er, st, po);
    vectors++;
    if (rd !== model[8] || er !== 1'b0) begin
      miscompares++;
      $display("FAIL err_store_dropped: rdata=%h err=%b, want %h 0", rd, er, model[8]);
    end
`else
    do_txn(1'b1, 32'd40, 32'h11, 0, 1'b0, lat, rd, er, st, po);
    ref_store(1'b0, 32'd40, 32'h11);
    do_txn(1'b0, 32'd8, 32'h0, 0, 1'b0, lat, rd, er, st, po);
    vectors++;
    if (lat != LAT || rd !== 32'h11 || er !== 1'b0 || !st || !po) begin
      miscompares++;
      $display("FAIL wrap_load8: lat=%0d rdata=%h err=%b stable=%b idle_after=%b, want lat=%0d rdata=11 err=0 1 1",
               lat, rd, er, st, po, LAT);
    end
`endif
  endtask

  task automatic test_random();
    int lat, hold; logic [31:0] rd, a, d, exp_rd; logic er, we, exp_er; bit st, po, junk;
    for (int t = 0; t < 40; t++) begin
      we   = 1'($urandom);
      a    = rand_addr();
      d    = $urandom;
      hold = $urandom_range(0, 3);
      junk = 1'($urandom);
      exp_rd = ref_rsp(1'b0, we, a);
      exp_er = ref_err(a);
      do_txn(we, a, d, hold, junk, lat, rd, er, st, po);
      if (we) ref_store(1'b0, a, d);
      vectors++;
      if (lat != LAT || rd !== exp_rd || er !== exp_er || !st || !po) begin
        miscompares++;
        $display("FAIL rand_%0d we=%b addr=%h: lat=%0d rdata=%h err=%b stable=%b idle_after=%b, want lat=%0d rdata=%h err=%b 1 1",
                 t, we, a, lat, rd, er, st, po, LAT, exp_rd, exp_er);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int lat, seen; logic [31:0] rd, a, d; logic er; bit st, po;
    a = 32'($urandom_range(0, DEPTH - 1));
    d = $urandom | 32'h1;
    do_txn(1'b1, a, d, 0, 1'b0, lat, rd, er, st, po);
    ref_store(1'b0, a, d);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midflight_wait: valid=%b ready=%b, want 0 0", rsp_valid, req_ready);
    end
    #2 RN = 1'b0;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL midflight_reset: valid=%b rdata=%h err=%b, want 0 0 0", rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (2) @(negedge clk);
    RN = 1'b1;
    clear_models();
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL midflight_discard: %0d cycles with response/busy, want 0", seen);
    end
    for (int k = 0; k < 4; k++) begin
      if (k > 0) a = 32'($urandom_range(0, DEPTH - 1));
      do_txn(1'b0, a, 32'h0, 0, 1'b0, lat, rd, er, st, po);
      vectors++;
      if (lat != LAT || rd !== ref_read(1'b0, a) || rd !== 32'd0 || er !== 1'b0) begin
        miscompares++;
        $display("FAIL cleared_load addr=%h: lat=%0d rdata=%h err=%b, want lat=%0d rdata=0 err=0",
                 a, lat, rd, er, LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d, exp_rd;
    logic exp_er, we;
    bit exp_ready;
    exp_rd = '0; exp_er = 1'b0;
    b_req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      exp_ready = (i % 2 == 0);
      vectors++;
      if (b_req_ready !== exp_ready || b_rsp_valid !== !exp_ready) begin
        miscompares++;
        $display("FAIL b2b_cycle_%0d: ready=%b valid=%b, want %b %b",
                 i, b_req_ready, b_rsp_valid, exp_ready, !exp_ready);
      end
      if (exp_ready) begin
        we = 1'($urandom);
        a  = rand_addr();
        d  = $urandom;
        b_req_we = we; b_req_addr = a; b_req_wdata = d;
        exp_rd = ref_rsp(1'b1, we, a);
        exp_er = ref_err(a);
        if (we) ref_store(1'b1, a, d);
      end else begin
        vectors++;
        if (b_rsp_rdata !== exp_rd || b_rsp_err !== exp_er) begin
          miscompares++;
          $display("FAIL b2b_rsp_%0d: rdata=%h err=%b, want %h %b",
                   i, b_rsp_rdata, b_rsp_err, exp_rd, exp_er);
        end
        b_req_we = 1'($urandom); b_req_addr = $urandom; b_req_wdata = $urandom;
      end
      @(negedge clk);
    end
    b_req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    RN = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    clear_models();
    test_reset();
    test_store_load();
    test_hold();
    test_addr_range();
    test_random();
    test_reset_midflight();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, want finished");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 32, meaning number of 32-bit data words held.
REQ-002 Parameter LATENCY, default 2, meaning cycles from request accept to response valid (legal range 1..4).
REQ-003 Port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 Port RN, input, 1, meaning asynchronous active-low reset.
REQ-005 Port req_valid, input, 1, meaning the pipeline is presenting a load/store request.
REQ-006 Port req_ready, output, 1, meaning the responder will accept a request this cycle.
REQ-007 Port req_we, input, 1, meaning store when high, load when low.
REQ-008 Port req_addr, input, 32, meaning word address.
REQ-009 Port req_wdata, input, 32, meaning store data.
REQ-010 Port rsp_valid, output, 1, meaning a response is presented.
REQ-011 Port rsp_ready, input, 1, meaning the pipeline takes the response this cycle.
REQ-012 Port rsp_rdata, output, 32, meaning load data, or 0 for stores and errors.
REQ-013 Port rsp_err, output, 1, meaning the accepted address was out of range.

Function
REQ-014 FSM states SHALL be IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE.
REQ-016 Accept SHALL occur on the rising edge where req_valid and req_ready are both 1.
REQ-017 On accept, a store SHALL write req_wdata to word req_addr at that same edge.
REQ-018 On accept, a load SHALL capture word req_addr into the response register at that same edge, so a later store cannot alter it.
REQ-019 On accept with LATENCY=1, the FSM SHALL go to RESP; otherwise it SHALL go to WAIT with the wait counter loaded to LATENCY-1.
REQ-020 In WAIT, the counter SHALL decrement once per cycle; the FSM SHALL go to RESP on the edge where the counter reaches 0.
REQ-021 rsp_valid SHALL be 1 exactly while in RESP, i.e. from accept edge + LATENCY cycles.
REQ-022 rsp_rdata and rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-023 RESP with rsp_ready=1 SHALL return the FSM to IDLE; the next request is accepted no earlier than the following edge.
REQ-024 Stores SHALL return rsp_rdata=0 with rsp_err set according to address checking.
REQ-025 The block SHALL have at most one outstanding request; req_* inputs SHALL be ignored outside IDLE.
REQ-026 Only the low 32 bits of req_addr SHALL be used; no arithmetic on data is performed.

Reset
REQ-027 Assertion of RN low SHALL immediately force the FSM to IDLE, the counter to 0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and req_ready=1 after release.
REQ-028 Reset SHALL clear all DEPTH words to 0.
REQ-029 Reset mid-operation SHALL discard any in-flight response; a store already written SHALL remain only if reset did not follow (storage is cleared regardless).

Configuration
REQ-030 Macro DMEM_RESPONDER_ERR_EN defined: req_addr >= DEPTH SHALL set rsp_err=1, drop the store and return rsp_rdata=0.
REQ-031 Macro DMEM_RESPONDER_ERR_EN undefined: the address SHALL wrap modulo DEPTH (low log2(DEPTH) bits), and rsp_err SHALL be constant 0.

Structure
REQ-032 Package dmem_pkg SHALL hold the FSM state typedef, the data width constant (32) and the LATENCY legal bounds.
REQ-033 Storage SHALL be a sub-module dmem_array (sync write, registered read capture, async clear); FSM and counter stay in dmem_responder.

Verification
REQ-034 Store addr 5, data 0xDEADBEEF, then load addr 5, LATENCY=2 -> load response rdata=0xDEADBEEF, rsp_valid exactly 2 cycles after each accept.
REQ-035 Load addr 3 with rsp_ready held 0 for 4 cycles -> rsp_valid, rdata and err stable for all 4 cycles; req_ready=0 throughout.
REQ-036 Load addr 40, ERR_EN defined -> rsp_err=1, rdata=0. ERR_EN undefined, store addr 40 data 0x11 then load addr 8 -> rdata=0x11.
REQ-037 Drive RN low during WAIT after a load accept -> rsp_valid=0 at once and never asserts for that request; a load of any address after release returns 0.
REQ-038 LATENCY=1 with back-to-back requests and rsp_ready tied to 1 -> one accept every 2 cycles, and each response arrives 1 cycle after its accept.
